// File: rtl/loopback_pkg.sv
// Shared definitions for the cdc_stream_loopback block: source modes, the
// per-byte transform and the FIFO pointer-width helper.
package loopback_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_INV   = 2'd1;
    localparam logic [1:0] MODE_INC   = 2'd2;
    localparam logic [1:0] MODE_CROSS = 2'd3;

    // Transform runs at the widest supported width; callers cast to WIDTH.
    localparam int XFORM_W = 64;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_PTR_W = ptr_width(16);

    function automatic logic [XFORM_W-1:0] xform(input logic [1:0] mode,
                                                  input logic [XFORM_W-1:0] d);
        case (mode)
            MODE_INV: return ~d;
            MODE_INC: return d + 64'd1;
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/loopback_fifo.sv
// First-word-fall-through FIFO with one extra pointer bit for full/empty
// and a registered occupancy count.
module loopback_fifo
    import loopback_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PW    = ptr_width(DEPTH),
    localparam int AW    = PW - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    // No full bypass: a pop in the same cycle does not free a slot for a push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    // Storage is not reset, so the head is masked while empty.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    assign level_o = level_q;

endmodule

// File: rtl/cdc_stream_loopback.sv
// Multi-channel CDC loopback: per-source transform/routing, lowest-index-wins
// write arbitration per destination FIFO. LOOPBACK_STATS_EN adds tx counters
// and sticky stall detection.
module cdc_stream_loopback
    import loopback_pkg::*;
#(
    parameter  int CHANNELS = 1,
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    localparam int PW       = ptr_width(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CHANNELS*WIDTH-1:0] rx_data_i,
    input  logic [CHANNELS-1:0]    rx_valid_i,
    output logic [CHANNELS-1:0]    rx_ready_o,
    output logic [CHANNELS*WIDTH-1:0] tx_data_o,
    output logic [CHANNELS-1:0]    tx_valid_o,
    input  logic [CHANNELS-1:0]    tx_ready_i,
    input  logic [2*CHANNELS-1:0]  mode_i,
`ifdef LOOPBACK_STATS_EN
    output logic [CHANNELS*16-1:0] tx_count_o,
    output logic [CHANNELS-1:0]    drop_o,
`endif
    output logic [CHANNELS*PW-1:0] level_o
);

    logic                             en_q;
    logic [CHANNELS-1:0]              win;
    logic [CHANNELS-1:0]              ready;
    logic [CHANNELS-1:0]              push;
    logic [CHANNELS-1:0]              pop;
    logic [CHANNELS-1:0]              full;
    logic [CHANNELS-1:0]              empty;
    logic [CHANNELS-1:0][WIDTH-1:0]   wdata;
    logic [CHANNELS-1:0][WIDTH-1:0]   rdata;
    logic [CHANNELS-1:0][PW-1:0]      level;
    int                               dest [CHANNELS];

    // Holds ready low through reset and for the first edge after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) en_q <= 1'b0;
        else       en_q <= 1'b1;
    end

    always_comb begin
        win   = '0;
        ready = '0;
        push  = '0;
        wdata = '0;
        for (int s = 0; s < CHANNELS; s++) begin
            dest[s] = (mode_i[2*s +: 2] == MODE_CROSS) ? (s + 1) % CHANNELS : s;
        end
        for (int s = 0; s < CHANNELS; s++) begin
            win[s] = rx_valid_i[s];
            for (int t = 0; t < s; t++) begin
                if (rx_valid_i[t] && dest[t] == dest[s]) win[s] = 1'b0;
            end
        end
        for (int s = 0; s < CHANNELS; s++) begin
            for (int d = 0; d < CHANNELS; d++) begin
                if (dest[s] == d && win[s] && en_q && !full[d]) begin
                    ready[s] = 1'b1;
                    push[d]  = 1'b1;
                    wdata[d] = WIDTH'(xform(mode_i[2*s +: 2],
                                            XFORM_W'(rx_data_i[s*WIDTH +: WIDTH])));
                end
            end
        end
    end

    assign rx_ready_o = ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        loopback_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[c]),
            .wdata_i (wdata[c]),
            .pop_i   (pop[c]),
            .rdata_o (rdata[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .level_o (level[c])
        );

        assign pop[c]                      = ~empty[c] & tx_ready_i[c];
        assign tx_valid_o[c]               = ~empty[c];
        assign tx_data_o[c*WIDTH +: WIDTH] = rdata[c];
        assign level_o[c*PW +: PW]         = level[c];

`ifdef LOOPBACK_STATS_EN
        logic [15:0] txc_q, txc_d;
        logic [7:0]  stall_q, stall_d;
        logic        drop_q, drop_d;
        logic        stall;

        assign stall = rx_valid_i[c] & ~rx_ready_o[c];

        // Stall counter saturates at 255; a further stalled cycle is the 256th.
        always_comb begin
            txc_d   = txc_q;
            stall_d = stall_q;
            drop_d  = drop_q;
            if (pop[c]) txc_d = txc_q + 16'd1;
            if (!stall) begin
                stall_d = '0;
            end else if (stall_q == 8'hFF) begin
                drop_d = 1'b1;
            end else begin
                stall_d = stall_q + 8'd1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                txc_q   <= '0;
                stall_q <= '0;
                drop_q  <= 1'b0;
            end else begin
                txc_q   <= txc_d;
                stall_q <= stall_d;
                drop_q  <= drop_d;
            end
        end

        assign tx_count_o[c*16 +: 16] = txc_q;
        assign drop_o[c]              = drop_q;
`endif
    end

endmodule

// File: tb/tb_cdc_stream_loopback.sv
// Directed bench for cdc_stream_loopback with CHANNELS=2, DEPTH=16.
// Stats checks compile in when LOOPBACK_STATS_EN is defined.
module tb_cdc_stream_loopback;

    logic        clk;
    logic        rst;
    logic [15:0] rx_data;
    logic [1:0]  rx_valid;
    logic [1:0]  rx_ready;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [3:0]  mode;
    logic [9:0]  level;
`ifdef LOOPBACK_STATS_EN
    logic [31:0] tx_count;
    logic [1:0]  drop;
`endif

    int checks = 0;
    int errors = 0;

    cdc_stream_loopback #(.CHANNELS(2), .WIDTH(8), .DEPTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .mode_i     (mode),
`ifdef LOOPBACK_STATS_EN
        .tx_count_o (tx_count),
        .drop_o     (drop),
`endif
        .level_o    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; rx_valid = 2'b01; rx_data = 16'h0011; mode = '0; tx_ready = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rx_ready !== 2'b00) begin errors++; $display("FAIL reset_rx_ready got=%b exp=00", rx_ready); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL reset_tx_valid got=%b exp=00", tx_valid); end
        checks++; if (tx_data !== 16'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0000", tx_data); end
        checks++; if (level !== 10'h0) begin errors++; $display("FAIL reset_level got=%h exp=000", level); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (rx_ready !== 2'b00) begin errors++; $display("FAIL ready_before_edge got=%b exp=00", rx_ready); end
        @(posedge clk); #1;
        checks++; if (rx_ready !== 2'b01) begin errors++; $display("FAIL ready_after_edge got=%b exp=01", rx_ready); end
        checks++; if (level !== 10'h0) begin errors++; $display("FAIL level_after_release got=%h exp=000", level); end
        rx_valid = 2'b00;
    endtask

    task automatic test_pass;
        mode = 4'b0000; tx_ready = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); rx_valid = 2'b01; rx_data = {8'h00, 8'(i)};
            @(posedge clk); #1;
            checks++;
            if (tx_valid !== 2'b01 || tx_data[7:0] !== 8'(i))
                begin errors++; $display("FAIL pass_byte%0d got=%b/%h exp=01/%h", i, tx_valid, tx_data[7:0], 8'(i)); end
        end
        @(negedge clk); rx_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (tx_valid !== 2'b00 || level !== 10'h0)
            begin errors++; $display("FAIL pass_drain got=%b/%h exp=00/000", tx_valid, level); end
        tx_ready = 2'b00;
    endtask

    task automatic test_transform;
        tx_ready = 2'b00;
        @(negedge clk); mode = 4'b0001; rx_valid = 2'b01; rx_data = 16'h00A5;
        @(negedge clk); mode = 4'b0010; rx_data = 16'h00FF;
        @(negedge clk); rx_valid = 2'b00; #1;
        checks++; if (level[4:0] !== 5'd2) begin errors++; $display("FAIL xform_level got=%0d exp=2", level[4:0]); end
        checks++; if (tx_data[7:0] !== 8'h5A) begin errors++; $display("FAIL xform_invert got=%h exp=5a", tx_data[7:0]); end
        tx_ready = 2'b01;
        @(posedge clk); #1;
        checks++; if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== 8'h00)
            begin errors++; $display("FAIL xform_inc_wrap got=%b/%h exp=1/00", tx_valid[0], tx_data[7:0]); end
        @(posedge clk); #1;
        checks++; if (tx_valid[0] !== 1'b0 || level[4:0] !== 5'd0)
            begin errors++; $display("FAIL xform_drain got=%b/%0d exp=0/0", tx_valid[0], level[4:0]); end
        tx_ready = 2'b00; mode = 4'b0000;
    endtask

    task automatic test_full;
        mode = 4'b0000; tx_ready = 2'b00;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk); rx_valid = 2'b01; rx_data = {8'h00, 8'h40 + 8'(i)}; #1;
            checks++;
            if (rx_ready[0] !== (i < 16))
                begin errors++; $display("FAIL full_ready%0d got=%b exp=%b", i, rx_ready[0], (i < 16)); end
        end
        @(posedge clk); #1;
        checks++; if (level[4:0] !== 5'd16 || rx_ready[0] !== 1'b0)
            begin errors++; $display("FAIL full_level got=%0d/%b exp=16/0", level[4:0], rx_ready[0]); end
        @(negedge clk); tx_ready = 2'b01; #1;
        checks++; if (rx_ready[0] !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", rx_ready[0]); end
        @(posedge clk); #1;
        checks++; if (level[4:0] !== 5'd15 || tx_data[7:0] !== 8'h41)
            begin errors++; $display("FAIL full_pop got=%0d/%h exp=15/41", level[4:0], tx_data[7:0]); end
        @(negedge clk); tx_ready = 2'b00; #1;
        checks++; if (rx_ready[0] !== 1'b1) begin errors++; $display("FAIL full_reopen got=%b exp=1", rx_ready[0]); end
        @(posedge clk); #1;
        checks++; if (level[4:0] !== 5'd16) begin errors++; $display("FAIL full_refill got=%0d exp=16", level[4:0]); end
        @(negedge clk); rx_valid = 2'b00; tx_ready = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++;
            if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== 8'h40 + 8'(i))
                begin errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, tx_valid[0], tx_data[7:0], 8'h40 + 8'(i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (tx_valid[0] !== 1'b0 || level[4:0] !== 5'd0)
            begin errors++; $display("FAIL full_empty got=%b/%0d exp=0/0", tx_valid[0], level[4:0]); end
        tx_ready = 2'b00;
    endtask

    task automatic test_cross;
        mode = 4'b0011; tx_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rx_valid = 2'b11; rx_data = {8'h20, 8'h10 + 8'(i)}; #1;
            checks++; if (rx_ready !== 2'b01) begin errors++; $display("FAIL cross_arb%0d got=%b exp=01", i, rx_ready); end
            @(posedge clk); #1;
            checks++;
            if (tx_valid !== 2'b10 || tx_data[15:8] !== 8'h10 + 8'(i))
                begin errors++; $display("FAIL cross_tx%0d got=%b/%h exp=10/%h", i, tx_valid, tx_data[15:8], 8'h10 + 8'(i)); end
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk); rx_valid = 2'b10; rx_data = {8'h20 + 8'(j), 8'h00}; #1;
            checks++; if (rx_ready !== 2'b10) begin errors++; $display("FAIL ch1_ready%0d got=%b exp=10", j, rx_ready); end
            @(posedge clk); #1;
            checks++;
            if (tx_valid !== 2'b10 || tx_data[15:8] !== 8'h20 + 8'(j))
                begin errors++; $display("FAIL ch1_tx%0d got=%b/%h exp=10/%h", j, tx_valid, tx_data[15:8], 8'h20 + 8'(j)); end
        end
        @(negedge clk); rx_valid = 2'b00;
        @(posedge clk); #1;
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL cross_drain got=%b exp=00", tx_valid); end
        mode = 4'b0000; tx_ready = 2'b00;
    endtask

    task automatic test_reset_mid;
        mode = 4'b0000; tx_ready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rx_valid = 2'b01; rx_data = {8'h00, 8'h30 + 8'(i)};
        end
        @(negedge clk);
        checks++; if (level[4:0] !== 5'd5) begin errors++; $display("FAIL mid_level5 got=%0d exp=5", level[4:0]); end
        rst = 1'b1; rx_data = 16'h0099; #1;
        checks++; if (level !== 10'h0) begin errors++; $display("FAIL mid_level0 got=%h exp=000", level); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL mid_tx_valid got=%b exp=00", tx_valid); end
        checks++; if (rx_ready !== 2'b00) begin errors++; $display("FAIL mid_rx_ready got=%b exp=00", rx_ready); end
        @(negedge clk); rst = 1'b0; rx_valid = 2'b00;
        @(negedge clk); rx_valid = 2'b01; rx_data = 16'h0077;
        @(posedge clk); #1;
        checks++; if (level[4:0] !== 5'd1 || tx_valid[0] !== 1'b1 || tx_data[7:0] !== 8'h77)
            begin errors++; $display("FAIL mid_resume got=%0d/%b/%h exp=1/1/77", level[4:0], tx_valid[0], tx_data[7:0]); end
        @(negedge clk); rx_valid = 2'b00; tx_ready = 2'b01;
        @(posedge clk); #1;
        checks++; if (level[4:0] !== 5'd0) begin errors++; $display("FAIL mid_drain got=%0d exp=0", level[4:0]); end
        tx_ready = 2'b00;
    endtask

`ifdef LOOPBACK_STATS_EN
    task automatic test_stats;
        @(negedge clk); rst = 1'b1; rx_valid = 2'b00; tx_ready = 2'b00; mode = 4'b0000;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (tx_count !== 32'h0) begin errors++; $display("FAIL stats_reset got=%h exp=0", tx_count); end
        @(negedge clk); tx_ready = 2'b01;
        for (int i = 0; i < 300; i++) begin
            rx_valid = 2'b01; rx_data = {8'h00, 8'(i)};
            @(negedge clk);
        end
        rx_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tx_count[15:0] !== 16'd300) begin errors++; $display("FAIL stats_count got=%0d exp=300", tx_count[15:0]); end
        checks++; if (tx_count[31:16] !== 16'd0) begin errors++; $display("FAIL stats_count1 got=%0d exp=0", tx_count[31:16]); end
        tx_ready = 2'b00; rx_valid = 2'b01;
        repeat (216) @(negedge clk);
        #1;
        checks++; if (drop !== 2'b00) begin errors++; $display("FAIL drop_early got=%b exp=00", drop); end
        repeat (60) @(negedge clk);
        #1;
        checks++; if (drop !== 2'b01) begin errors++; $display("FAIL drop_set got=%b exp=01", drop); end
        rx_valid = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_transform();
        test_full();
        test_cross();
        test_reset_mid();
`ifdef LOOPBACK_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
